// File: rtl/mem_ctrl_param.sv
// -----------------------------------------------------------------------------
// mem_ctrl_param
//
// Parametrised two-channel memory controller. It sits between a traffic source
// and a modelled storage array. There is one write request channel and one read
// request channel. Each channel has its own fixed-latency return channel.
// A periodic refresh state machine stops both channels from accepting requests
// while a refresh is in progress.
//
// Optional feature (compile-time macro MC_STATS_EN):
//   defined   -> adds the wr_count, rd_count (32 bit) and refresh_count
//                (16 bit) statistics outputs
//   undefined -> those ports and counters are absent
//
// Parameters:
//   ADDR_W          request/return address width
//   DATA_W          data width
//   DEPTH           number of words in the array (power of two, <= 2**ADDR_W)
//   WR_LAT          edges from write acceptance to wr_ret_ack (>= 1)
//   RD_LAT          edges from read acceptance to rd_ret_ack (>= 1)
//   REFRESH_PERIOD  NORMAL cycles between refreshes (0 disables refresh)
//   REFRESH_CYCLES  cycles spent in REFRESH (>= 1)
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   wr_en           write request valid
//   wr_address      write address
//   wr_data         write data
//   wr_ready        write channel accepting
//   wr_ret_ack      one-cycle write completion pulse
//   wr_ret_address  address of the completed write
//   rd_en           read request valid
//   rd_address      read address
//   rd_ready        read channel accepting
//   rd_ret_ack      one-cycle read return pulse
//   rd_ret_address  address of the returned read
//   rd_ret_data     returned data; holds its last value while rd_ret_ack is low
//   in_refresh      high while the FSM is in REFRESH
//   wr_count        accepted writes            (MC_STATS_EN only)
//   rd_count        accepted reads             (MC_STATS_EN only)
//   refresh_count   NORMAL->REFRESH transitions (MC_STATS_EN only)
//
// Refresh FSM states:
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_NORMAL  | requests accepted; ref_cnt counts toward the next refresh
//   ST_REFRESH | readies low; ref_cnt counts the refresh duration
// -----------------------------------------------------------------------------
module mem_ctrl_param #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 256,
    parameter int WR_LAT         = 1,
    parameter int RD_LAT         = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_ret_ack,
    output logic [ADDR_W-1:0] wr_ret_address,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_ready,
    output logic              rd_ret_ack,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic [DATA_W-1:0] rd_ret_data,
    output logic              in_refresh
`ifdef MC_STATS_EN
    ,
    output logic [31:0]       wr_count,
    output logic [31:0]       rd_count,
    output logic [15:0]       refresh_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_REFRESH = 2'd1;

    localparam bit          REFRESH_EN = (REFRESH_PERIOD > 0);
    localparam logic [31:0] PER_LAST   = (REFRESH_PERIOD > 0) ? 32'(REFRESH_PERIOD - 1) : 32'd0;
    localparam logic [31:0] REF_LAST   = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;

    // ------------------------------------------------------------------
    // Refresh FSM
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [31:0] ref_cnt;
    logic        ready_q;
    logic        in_refresh_q;
    logic        refresh_start;

    assign refresh_start = REFRESH_EN && (state == ST_NORMAL) && (ref_cnt == PER_LAST);

    // Ready and in_refresh are registered alongside the state so they switch
    // on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_NORMAL;
            ref_cnt      <= 32'd0;
            ready_q      <= 1'b1;
            in_refresh_q <= 1'b0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (refresh_start) begin
                        state        <= ST_REFRESH;
                        ref_cnt      <= 32'd0;
                        ready_q      <= 1'b0;
                        in_refresh_q <= 1'b1;
                    end else if (REFRESH_EN) begin
                        ref_cnt <= ref_cnt + 32'd1;
                    end
                end
                ST_REFRESH: begin
                    if (ref_cnt == REF_LAST) begin
                        state        <= ST_NORMAL;
                        ref_cnt      <= 32'd0;
                        ready_q      <= 1'b1;
                        in_refresh_q <= 1'b0;
                    end else begin
                        ref_cnt <= ref_cnt + 32'd1;
                    end
                end
                default: begin
                    state        <= ST_NORMAL;
                    ref_cnt      <= 32'd0;
                    ready_q      <= 1'b1;
                    in_refresh_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready   = ready_q;
    assign rd_ready   = ready_q;
    assign in_refresh = in_refresh_q;

    // ------------------------------------------------------------------
    // Acceptance and storage
    // ------------------------------------------------------------------
    logic             wr_acc;
    logic             rd_acc;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_acc = wr_en & ready_q;
    assign rd_acc = rd_en & ready_q;

    // Only the low address bits select the word, so higher bits alias.
    assign wr_idx = wr_address[IDX_W-1:0];
    assign rd_idx = rd_address[IDX_W-1:0];

    // The array is not reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Write-first: a read that hits the word being written on the same edge
    // returns the new data instead of the stale array contents.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_acc && (wr_idx == rd_idx)) begin
            rd_word = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Write return pipeline: stage 0 loads on the accept edge, and the last
    // stage drives the return outputs.
    // ------------------------------------------------------------------
    logic              wr_vld [WR_LAT];
    logic [ADDR_W-1:0] wr_adr [WR_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_LAT; i++) begin
                wr_vld[i] <= 1'b0;
                wr_adr[i] <= '0;
            end
        end else begin
            wr_vld[0] <= wr_acc;
            if (wr_acc) begin
                wr_adr[0] <= wr_address;
            end
            for (int i = 1; i < WR_LAT; i++) begin
                wr_vld[i] <= wr_vld[i-1];
                if (wr_vld[i-1]) begin
                    wr_adr[i] <= wr_adr[i-1];
                end
            end
        end
    end

    assign wr_ret_ack     = wr_vld[WR_LAT-1];
    assign wr_ret_address = wr_adr[WR_LAT-1];

    // ------------------------------------------------------------------
    // Read return pipeline. A payload register only moves when valid data
    // moves into it, so the last stage keeps the last returned data while
    // no return is present.
    // ------------------------------------------------------------------
    logic              rd_vld [RD_LAT];
    logic [ADDR_W-1:0] rd_adr [RD_LAT];
    logic [DATA_W-1:0] rd_dat [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld[i] <= 1'b0;
                rd_adr[i] <= '0;
                rd_dat[i] <= '0;
            end
        end else begin
            rd_vld[0] <= rd_acc;
            if (rd_acc) begin
                rd_adr[0] <= rd_address;
                rd_dat[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                if (rd_vld[i-1]) begin
                    rd_adr[i] <= rd_adr[i-1];
                    rd_dat[i] <= rd_dat[i-1];
                end
            end
        end
    end

    assign rd_ret_ack     = rd_vld[RD_LAT-1];
    assign rd_ret_address = rd_adr[RD_LAT-1];
    assign rd_ret_data    = rd_dat[RD_LAT-1];

`ifdef MC_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count      <= 32'd0;
            rd_count      <= 32'd0;
            refresh_count <= 16'd0;
        end else begin
            if (wr_acc) begin
                wr_count <= wr_count + 32'd1;
            end
            if (rd_acc) begin
                rd_count <= rd_count + 32'd1;
            end
            if (refresh_start) begin
                refresh_count <= refresh_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_param
//
// Testbench for mem_ctrl_param. It uses three instances:
//   u_a : default widths and latencies, refresh disabled; a table of vectors
//         (write/read-back, same-edge write-first, data hold)
//   u_b : REFRESH_PERIOD=8, REFRESH_CYCLES=3; refresh window, a read held
//         across the window, and a read returning during refresh
//   u_c : DEPTH=16, RD_LAT=4, refresh disabled; address aliasing and a reset
//         while a read is in flight
// -----------------------------------------------------------------------------
module tb_mem_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A signals ----------------
    logic        a_rst_n, a_wr_en, a_rd_en;
    logic [15:0] a_wr_address, a_wr_data, a_rd_address;
    logic        a_wr_ready, a_wr_ret_ack, a_rd_ready, a_rd_ret_ack, a_in_refresh;
    logic [15:0] a_wr_ret_address, a_rd_ret_address, a_rd_ret_data;
    // ---------------- instance B signals ----------------
    logic        b_rst_n, b_wr_en, b_rd_en;
    logic [15:0] b_wr_address, b_wr_data, b_rd_address;
    logic        b_wr_ready, b_wr_ret_ack, b_rd_ready, b_rd_ret_ack, b_in_refresh;
    logic [15:0] b_wr_ret_address, b_rd_ret_address, b_rd_ret_data;
    // ---------------- instance C signals ----------------
    logic        c_rst_n, c_wr_en, c_rd_en;
    logic [15:0] c_wr_address, c_wr_data, c_rd_address;
    logic        c_wr_ready, c_wr_ret_ack, c_rd_ready, c_rd_ret_ack, c_in_refresh;
    logic [15:0] c_wr_ret_address, c_rd_ret_address, c_rd_ret_data;

`ifdef MC_STATS_EN
    logic [31:0] a_wr_count, a_rd_count, b_wr_count, b_rd_count, c_wr_count, c_rd_count;
    logic [15:0] a_refresh_count, b_refresh_count, c_refresh_count;
`endif

    mem_ctrl_param #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(256), .WR_LAT(1), .RD_LAT(2),
        .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .wr_en(a_wr_en), .wr_address(a_wr_address), .wr_data(a_wr_data),
        .wr_ready(a_wr_ready), .wr_ret_ack(a_wr_ret_ack), .wr_ret_address(a_wr_ret_address),
        .rd_en(a_rd_en), .rd_address(a_rd_address), .rd_ready(a_rd_ready),
        .rd_ret_ack(a_rd_ret_ack), .rd_ret_address(a_rd_ret_address), .rd_ret_data(a_rd_ret_data),
        .in_refresh(a_in_refresh)
`ifdef MC_STATS_EN
        , .wr_count(a_wr_count), .rd_count(a_rd_count), .refresh_count(a_refresh_count)
`endif
    );

    mem_ctrl_param #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(256), .WR_LAT(1), .RD_LAT(2),
        .REFRESH_PERIOD(8), .REFRESH_CYCLES(3)
    ) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .wr_en(b_wr_en), .wr_address(b_wr_address), .wr_data(b_wr_data),
        .wr_ready(b_wr_ready), .wr_ret_ack(b_wr_ret_ack), .wr_ret_address(b_wr_ret_address),
        .rd_en(b_rd_en), .rd_address(b_rd_address), .rd_ready(b_rd_ready),
        .rd_ret_ack(b_rd_ret_ack), .rd_ret_address(b_rd_ret_address), .rd_ret_data(b_rd_ret_data),
        .in_refresh(b_in_refresh)
`ifdef MC_STATS_EN
        , .wr_count(b_wr_count), .rd_count(b_rd_count), .refresh_count(b_refresh_count)
`endif
    );

    mem_ctrl_param #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(16), .WR_LAT(1), .RD_LAT(4),
        .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) u_c (
        .clk(clk), .rst_n(c_rst_n),
        .wr_en(c_wr_en), .wr_address(c_wr_address), .wr_data(c_wr_data),
        .wr_ready(c_wr_ready), .wr_ret_ack(c_wr_ret_ack), .wr_ret_address(c_wr_ret_address),
        .rd_en(c_rd_en), .rd_address(c_rd_address), .rd_ready(c_rd_ready),
        .rd_ret_ack(c_rd_ret_ack), .rd_ret_address(c_rd_ret_address), .rd_ret_data(c_rd_ret_data),
        .in_refresh(c_in_refresh)
`ifdef MC_STATS_EN
        , .wr_count(c_wr_count), .rd_count(c_rd_count), .refresh_count(c_refresh_count)
`endif
    );

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        e_wr_ack;
        logic [15:0] e_wr_addr;
        logic        e_rd_ack;
        logic [15:0] e_rd_addr;
        logic [15:0] e_rd_data;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vt [NVEC];

    function automatic vec_t mk(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                                input logic re, input logic [15:0] ra,
                                input logic ewa, input logic [15:0] ewad,
                                input logic era, input logic [15:0] erad, input logic [15:0] erd);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd;
        v.rd_en = re;  v.rd_addr = ra;
        v.e_wr_ack = ewa; v.e_wr_addr = ewad;
        v.e_rd_ack = era; v.e_rd_addr = erad; v.e_rd_data = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b_acks;

        // ---------------- vector table for instance A ----------------
        // Outputs are sampled just after the edge that consumes the inputs.
        vt[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        for (int j = 0; j < 10; j++)   // writes to 150..159, data 0..9
            vt[2+j] = mk(1, 16'(150+j), 16'(j), 0, 0, 1, 16'(150+j), 0, 0, 16'h0000);
        vt[12] = mk(0, 0, 0, 1, 16'd150, 0, 0, 0, 0, 16'h0000);
        for (int j = 1; j < 10; j++)   // reads of 151..159, each returns the previous read
            vt[12+j] = mk(0, 0, 0, 1, 16'(150+j), 0, 0, 1, 16'(150+j-1), 16'(j-1));
        vt[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'd159, 16'd9);
        vt[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd9);
        vt[24] = mk(1, 16'h0020, 16'h1111, 0, 0, 1, 16'h0020, 0, 0, 16'd9);
        vt[25] = mk(1, 16'h0020, 16'hBEEF, 1, 16'h0020, 1, 16'h0020, 0, 0, 16'd9);
        vt[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 16'hBEEF);
        vt[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF);

        a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
        a_wr_en = 0; a_rd_en = 0; a_wr_address = 0; a_wr_data = 0; a_rd_address = 0;
        b_wr_en = 0; b_rd_en = 0; b_wr_address = 0; b_wr_data = 0; b_rd_address = 0;
        c_wr_en = 0; c_rd_en = 0; c_wr_address = 0; c_wr_data = 0; c_rd_address = 0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_a_wr_ack",   a_wr_ret_ack, 0);
        chk("rst_a_rd_ack",   a_rd_ret_ack, 0);
        chk("rst_a_wr_ready", a_wr_ready,   1);
        chk("rst_a_rd_ready", a_rd_ready,   1);
        chk("rst_a_in_ref",   a_in_refresh, 0);
        chk("rst_a_rd_data",  a_rd_ret_data, 0);
        chk("rst_b_wr_ready", b_wr_ready,   1);
        chk("rst_b_in_ref",   b_in_refresh, 0);

        // ---------------- instance A: table ----------------
        a_rst_n = 1;
        for (int i = 0; i < NVEC; i++) begin
            a_wr_en = vt[i].wr_en; a_wr_address = vt[i].wr_addr; a_wr_data = vt[i].wr_data;
            a_rd_en = vt[i].rd_en; a_rd_address = vt[i].rd_addr;
            tick();
            chk($sformatf("a_wr_ack[%0d]", i), a_wr_ret_ack, vt[i].e_wr_ack);
            chk($sformatf("a_rd_ack[%0d]", i), a_rd_ret_ack, vt[i].e_rd_ack);
            chk($sformatf("a_rd_data[%0d]", i), a_rd_ret_data, vt[i].e_rd_data);
            chk($sformatf("a_ready[%0d]", i), {a_wr_ready, a_rd_ready, a_in_refresh}, 3'b110);
            if (vt[i].e_wr_ack)
                chk($sformatf("a_wr_addr[%0d]", i), a_wr_ret_address, vt[i].e_wr_addr);
            if (vt[i].e_rd_ack)
                chk($sformatf("a_rd_addr[%0d]", i), a_rd_ret_address, vt[i].e_rd_addr);
        end
        a_wr_en = 0; a_rd_en = 0;

        // ---------------- instance B: refresh window ----------------
        // Edge n after release: readies low after edges 8,9,10 and 19,20,21.
        // Read at edge 8 returns after edge 9 (inside the window); the read
        // held from edge 9 is first accepted at edge 12 and returns after 13.
        b_rst_n = 1;
        b_acks = 0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            b_wr_en = (cyc == 1); b_wr_address = 16'd5; b_wr_data = 16'h55AA;
            b_rd_en = (cyc >= 8 && cyc <= 12); b_rd_address = 16'd5;
            tick();
            if ((cyc >= 8 && cyc <= 10) || (cyc >= 19 && cyc <= 21)) begin
                chk($sformatf("b_ready_low[%0d]", cyc), {b_wr_ready, b_rd_ready, b_in_refresh}, 3'b001);
            end else begin
                chk($sformatf("b_ready_high[%0d]", cyc), {b_wr_ready, b_rd_ready, b_in_refresh}, 3'b110);
            end
            chk($sformatf("b_wr_ack[%0d]", cyc), b_wr_ret_ack, (cyc == 1) ? 1 : 0);
            chk($sformatf("b_rd_ack[%0d]", cyc), b_rd_ret_ack, (cyc == 9 || cyc == 13) ? 1 : 0);
            if (b_rd_ret_ack) begin
                b_acks++;
                chk($sformatf("b_rd_data[%0d]", cyc), b_rd_ret_data, 16'h55AA);
                chk($sformatf("b_rd_addr[%0d]", cyc), b_rd_ret_address, 16'd5);
            end
        end
        b_wr_en = 0; b_rd_en = 0;
        chk("b_total_rd_acks", b_acks, 2);

        // ---------------- instance C: aliasing ----------------
        c_rst_n = 1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            c_wr_en = (cyc == 1); c_wr_address = 16'h0013; c_wr_data = 16'hAAAA;
            c_rd_en = (cyc == 2); c_rd_address = 16'h0003;
            tick();
            chk($sformatf("c_alias_ack[%0d]", cyc), c_rd_ret_ack, (cyc == 5) ? 1 : 0);
            if (cyc == 5) begin
                chk("c_alias_data", c_rd_ret_data, 16'hAAAA);
                chk("c_alias_addr", c_rd_ret_address, 16'h0003);
            end
        end
        c_wr_en = 0; c_rd_en = 0;

        // ---------------- instance C: reset with a read in flight ----------------
        c_wr_en = 1; c_wr_address = 16'h0007; c_wr_data = 16'h1234;
        tick();
        c_wr_en = 0;
        c_rd_en = 1; c_rd_address = 16'h0007;
        tick();                       // read accepted here
        c_rd_en = 0;
        tick();                       // one edge later
        c_rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("c_rst_rd_ack[%0d]", k), c_rd_ret_ack, 0);
            chk($sformatf("c_rst_ready[%0d]", k), {c_wr_ready, c_rd_ready}, 2'b11);
        end
        c_rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("c_post_rd_ack[%0d]", k), c_rd_ret_ack, 0);
        end
        c_rd_en = 1; c_rd_address = 16'h0007;
        tick();
        c_rd_en = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("c_reread_ack[%0d]", k), c_rd_ret_ack, (k == 3) ? 1 : 0);
        end
        chk("c_reread_data", c_rd_ret_data, 16'h1234);
        chk("c_reread_addr", c_rd_ret_address, 16'h0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
